tag_search_ctrl: RTL and testbench
==================================

TAG_SEARCH_CTRL -- requirements
Module: tag_search_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of tag entries; legal values 2..16.
REQ-002 Parameter IDX_W, default $clog2(DEPTH), width of entry indices.
REQ-003 Port clk  in  1  single clock, all state on rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port wr_valid  in  1  table write request.
REQ-006 Port wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-007 Port wr_idx  in  IDX_W  entry to write.
REQ-008 Port wr_tag  in  3  tag value to store.
REQ-009 Port wr_vld  in  1  new entry-valid bit; 0 invalidates the entry.
REQ-010 Port req_valid  in  1  search request.
REQ-011 Port req_ready  out  1  search accepted when req_valid && req_ready.
REQ-012 Port req_key  in  3  key to search for.
REQ-013 Port rsp_valid  out  1  search result available.
REQ-014 Port rsp_ready  in  1  result consumed when rsp_valid && rsp_ready.
REQ-015 Port rsp_hit  out  1  1 = a valid entry matched the key.
REQ-016 Port rsp_idx  out  IDX_W  lowest matching index; 0 on miss.
REQ-017 Port search_cnt  out  8  completed searches, saturating at 255.

Function
REQ-018 FSM states IDLE, SCAN, DONE; one state register.
REQ-019 wr_ready = (state==IDLE); a write updates tag[wr_idx] and vld[wr_idx] on the accepting edge.
REQ-020 req_ready = (state==IDLE) && !wr_valid; a write offered in the same IDLE cycle wins, and the request waits.
REQ-021 On request acceptance: latch req_key, set scan index to 0, go to SCAN.
REQ-022 In SCAN, exactly one entry, tag[idx], is compared per cycle, through a single comparator instance.
REQ-023 SCAN with vld[idx] && EQ: set rsp_hit=1 and rsp_idx=idx, then go to DONE.
REQ-024 SCAN with no match and idx==DEPTH-1: set rsp_hit=0 and rsp_idx=0, then go to DONE.
REQ-025 SCAN otherwise: idx increments by 1 and the state stays SCAN; idx never wraps.
REQ-026 Latency: a hit at index i asserts rsp_valid i+1 cycles after acceptance; a miss asserts it DEPTH cycles after.
REQ-027 rsp_valid = (state==DONE); rsp_hit and rsp_idx are held stable while rsp_valid && !rsp_ready.
REQ-028 DONE with rsp_ready: go to IDLE and increment search_cnt unless it is already 255.
REQ-029 The table is frozen outside IDLE; search results reflect table contents at acceptance.
REQ-030 Entries with vld=0 never match, even when the stored tag equals the key.
REQ-031 Duplicate valid tags: the lowest index is reported.
REQ-032 No combinational path from req_valid or rsp_ready to any output except through state.

Reset
REQ-033 While rst_n==0 at a clock edge: state=IDLE, all vld=0, idx=0, rsp_hit=0, rsp_idx=0, search_cnt=0.
REQ-034 Tag storage is not reset; it is unobservable while vld=0.
REQ-035 Reset mid-SCAN or in DONE aborts the search with no response and no count increment.
REQ-036 Outputs after reset: wr_ready=1, req_ready=!wr_valid, rsp_valid=0.

Structure
REQ-037 Package tag_search_pkg holds TAG_W=3 and the state enum typedef.
REQ-038 Instantiate comparator_3bit once as the sole compare datapath: A=tag[idx], B=latched key, EQ drives the match.
REQ-039 The existing comparator_3bit SVA bind stays active on the instance.

Verification
REQ-040 Write tags 0..7 = 5,3,7,3,0,1,2,6 with all vld=1; search key 3 -> rsp_hit=1, rsp_idx=1, rsp_valid 2 cycles after acceptance.
REQ-041 Same table, search key 4 -> rsp_hit=0, rsp_idx=0, rsp_valid 8 cycles after acceptance.
REQ-042 Invalidate entry 1 (wr_vld=0), search key 3 -> rsp_idx=3.
REQ-043 Hold rsp_ready=0 for 5 cycles in DONE -> rsp outputs stable, req_ready=0, wr_ready=0; then rsp_ready=1 -> IDLE, search_cnt +1.
REQ-044 wr_valid and req_valid both high in IDLE -> write accepted first, request accepted the next cycle and sees the new tag.
REQ-045 rst_n=0 at scan idx 4 -> next cycle IDLE, rsp_valid=0, all vld=0, search_cnt=0; then 256 searches -> search_cnt=255.

Source files
------------

// File: rtl/tag_search_pkg.sv
// Shared constants and FSM state encoding for the tag search controller.
package tag_search_pkg;
    localparam int TAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/comparator_3bit.sv
// 3-bit equality comparator; the only compare datapath in the search engine.
module comparator_3bit (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       EQ
);
    assign EQ = (A == B);
endmodule

// File: rtl/comparator_3bit_sva.sv
// Equality check bound onto every comparator_3bit instance.
module comparator_3bit_sva (
    input logic [2:0] A,
    input logic [2:0] B,
    input logic       EQ
);
    always_comb begin
        assert (EQ == (A == B));
    end
endmodule

bind comparator_3bit comparator_3bit_sva u_comparator_3bit_sva (
    .A  (A),
    .B  (B),
    .EQ (EQ)
);

// File: rtl/tag_search_ctrl.sv
// Tag table with a sequential one-entry-per-cycle search engine that
// reports the lowest valid index whose tag matches the requested key.
module tag_search_ctrl
    import tag_search_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_vld,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [7:0]       search_cnt
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   key_q, key_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [DEPTH-1:0]   wr_en;
    logic               wr_fire;
    logic               req_fire;
    logic [TAG_W-1:0]   cur_tag;
    logic               tag_eq;

    assign wr_ready  = (state_q == IDLE);
    assign req_ready = (state_q == IDLE) && !wr_valid;
    assign rsp_valid = (state_q == DONE);
    assign rsp_hit   = hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign search_cnt = cnt_q;

    assign wr_fire  = wr_valid && wr_ready;
    assign req_fire = req_valid && req_ready;

    // Writes are only accepted in IDLE, so the table is frozen during a search.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = wr_fire && (wr_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                tag_mem[i] <= wr_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    vld_q[i] <= wr_vld;
                end
            end
        end
    end

    assign cur_tag = tag_mem[idx_q];

    comparator_3bit u_cmp (
        .A  (cur_tag),
        .B  (key_q),
        .EQ (tag_eq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            hit_q     <= 1'b0;
            rsp_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            hit_q     <= hit_d;
            rsp_idx_q <= rsp_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        hit_d     = hit_q;
        rsp_idx_d = rsp_idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    key_d   = req_key;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Scanning upward means the first match is the lowest index.
                if (vld_q[idx_q] && tag_eq) begin
                    hit_d     = 1'b1;
                    rsp_idx_d = idx_q;
                    state_d   = DONE;
                end else if (idx_q == LAST_IDX) begin
                    hit_d     = 1'b0;
                    rsp_idx_d = '0;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tag_search_ctrl.sv
// Self-checking bench for tag_search_ctrl: vector table plus corner sequences.
module tb_tag_search_ctrl;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [2:0]       wr_tag;
    logic             wr_vld;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_key;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_idx;
    logic [7:0]       search_cnt;

    always #5 clk = ~clk;

    tag_search_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_tag     (wr_tag),
        .wr_vld     (wr_vld),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_idx    (rsp_idx),
        .search_cnt (search_cnt)
    );

    typedef struct {
        logic [2:0] key;
        bit         hit;
        int         idx;
        int         lat;
    } vec_t;

    vec_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wr(input int idx, input int tag, input bit vld);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_idx   = IDX_W'(idx);
        wr_tag   = 3'(tag);
        wr_vld   = vld;
        #1;
        chk("wr_ready", 32'(wr_ready), 1);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        $display("write idx=%0d tag=%0d vld=%0d", idx, tag, vld);
    endtask

    // Leaves the bench at the falling edge just after the accepting edge.
    task automatic issue(input vec_t v);
        sb.push_back(v);
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = v.key;
        #1;
        chk("req_ready", 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect(input bit hold);
        vec_t e;
        int   lat = 0;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_hit", 32'(rsp_hit), 32'(e.hit));
                chk("hold_idx", 32'(rsp_idx), 32'(e.idx));
                chk("hold_req_ready", 32'(req_ready), 0);
                chk("hold_wr_ready", 32'(wr_ready), 0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (exp_cnt < 255) exp_cnt++;
        chk("search_cnt", 32'(search_cnt), 32'(exp_cnt));
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("idle_wr_ready", 32'(wr_ready), 1);
        $display("search key=%0d hit=%0d idx=%0d lat=%0d cnt=%0d",
                 e.key, rsp_hit, rsp_idx, lat, search_cnt);
    endtask

    initial begin
        int   tags [8] = '{5, 3, 7, 3, 0, 1, 2, 6};
        vec_t vecs [6];
        vec_t v;

        vecs[0] = '{key: 3'd3, hit: 1'b1, idx: 1, lat: 2};
        vecs[1] = '{key: 3'd4, hit: 1'b0, idx: 0, lat: 8};
        vecs[2] = '{key: 3'd5, hit: 1'b1, idx: 0, lat: 1};
        vecs[3] = '{key: 3'd6, hit: 1'b1, idx: 7, lat: 8};
        vecs[4] = '{key: 3'd0, hit: 1'b1, idx: 4, lat: 5};
        vecs[5] = '{key: 3'd2, hit: 1'b1, idx: 6, lat: 7};

        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_idx    = '0;
        wr_tag    = '0;
        wr_vld    = 1'b0;
        req_valid = 1'b0;
        req_key   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_wr_ready", 32'(wr_ready), 1);
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_rsp_hit", 32'(rsp_hit), 0);
        chk("reset_rsp_idx", 32'(rsp_idx), 0);
        chk("reset_search_cnt", 32'(search_cnt), 0);

        for (int i = 0; i < 8; i++) wr(i, tags[i], 1'b1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i]);
            collect(1'b0);
        end

        // Invalidated entries must not match even with an equal stored tag.
        wr(1, 3, 1'b0);
        issue('{key: 3'd3, hit: 1'b1, idx: 3, lat: 4});
        collect(1'b0);
        wr(4, 0, 1'b0);
        issue('{key: 3'd0, hit: 1'b0, idx: 0, lat: 8});
        collect(1'b0);

        issue('{key: 3'd1, hit: 1'b1, idx: 5, lat: 6});
        collect(1'b1);

        // Simultaneous write and request: write goes first, search sees it.
        sb.push_back('{key: 3'd4, hit: 1'b1, idx: 2, lat: 3});
        @(negedge clk);
        wr_valid  = 1'b1;
        wr_idx    = 3'd2;
        wr_tag    = 3'd4;
        wr_vld    = 1'b1;
        req_valid = 1'b1;
        req_key   = 3'd4;
        #1;
        chk("both_req_ready", 32'(req_ready), 0);
        chk("both_wr_ready", 32'(wr_ready), 1);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("after_wr_req_ready", 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        collect(1'b0);

        // Reset while the scan is at index 4 aborts the search.
        issue('{key: 3'd7, hit: 1'b0, idx: 0, lat: 8});
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_wr_ready", 32'(wr_ready), 1);
        chk("abort_search_cnt", 32'(search_cnt), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 0);
        chk("abort_cnt_hold", 32'(search_cnt), 0);

        issue('{key: 3'd5, hit: 1'b0, idx: 0, lat: 8});
        collect(1'b0);
        issue('{key: 3'd6, hit: 1'b0, idx: 0, lat: 8});
        collect(1'b0);

        wr(0, 1, 1'b1);
        v = '{key: 3'd1, hit: 1'b1, idx: 0, lat: 1};
        for (int n = 0; n < 256; n++) begin
            issue(v);
            collect(1'b0);
        end
        chk("saturated_cnt", 32'(search_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
